// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback shares the port with a
// FIFO of long-latency results that drain into idle slots or force a stall when starved.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_we,
    input  logic [5:0]    pipe_waddr,
    input  logic [31:0]   pipe_wdata,
    output logic          pipe_stall,
    input  logic          ll_valid,
    input  logic [5:0]    ll_waddr,
    input  logic [31:0]   ll_wdata,
    output logic          ll_ready,
    output logic          rf_we,
    output logic [5:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic          ll_pending,
    output logic [CW-1:0] ll_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [DEPTH-1:0] live_q, live_d;
    logic [5:0]       waddr_q [DEPTH];
    logic [5:0]       waddr_d [DEPTH];
    logic [31:0]      wdata_q [DEPTH];
    logic [31:0]      wdata_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;

    logic not_empty, head_live, pipe_valid, forced;
    logic grant_head, grant_pipe, push, pop, enq_live;

    always_comb begin
        not_empty  = (count_q != '0);
        head_live  = not_empty & live_q[rd_ptr_q];
        // Pipe requests are masked during reset so every output shows its reset value.
        pipe_valid = pipe_we & (pipe_waddr != 6'd0) & ~reset;
        forced     = head_live & (starve_q == SW'(STARVE_LIMIT));
        grant_head = forced | (head_live & ~pipe_valid);
        grant_pipe = pipe_valid & ~forced;
        ll_ready   = (count_q < CW'(DEPTH));
        push       = ll_valid & ll_ready;
        pop        = not_empty & (grant_head | ~live_q[rd_ptr_q]);
        enq_live   = (ll_waddr != 6'd0) & ~(grant_pipe & (ll_waddr == pipe_waddr));

        pipe_stall = forced & pipe_valid;
        rf_we      = grant_head | grant_pipe;
        rf_waddr   = 6'd0;
        rf_wdata   = 32'd0;
        if (grant_head) begin
            rf_waddr = waddr_q[rd_ptr_q];
            rf_wdata = wdata_q[rd_ptr_q];
        end else if (grant_pipe) begin
            rf_waddr = pipe_waddr;
            rf_wdata = pipe_wdata;
        end
        ll_pending = not_empty;
        ll_count   = count_q;
    end

    always_comb begin
        live_d   = live_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;

        // A granted pipe write is younger than anything buffered for the same register.
        if (grant_pipe) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr_q[i] == pipe_waddr) begin
                    live_d[i] = 1'b0;
                end
            end
        end

        if (push) begin
            live_d[wr_ptr_q]  = enq_live;
            waddr_d[wr_ptr_q] = ll_waddr;
            wdata_d[wr_ptr_q] = ll_wdata;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (!head_live || grant_head) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= 6'd0;
                wdata_q[i] <= 32'd0;
            end
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= waddr_d[i];
                wdata_q[i] <= wdata_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected register-file writes are queued as
// stimulus is driven and matched against every rf_we observed on the falling edge.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [5:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_stall;
    logic        ll_valid;
    logic [5:0]  ll_waddr;
    logic [31:0] ll_wdata;
    logic        ll_ready;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ll_pending;
    logic [1:0]  ll_count;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];
    wr_t monEntry;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .pipe_stall (pipe_stall),
        .ll_valid   (ll_valid),
        .ll_waddr   (ll_waddr),
        .ll_wdata   (ll_wdata),
        .ll_ready   (ll_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .ll_pending (ll_pending),
        .ll_count   (ll_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic pwe, input logic [5:0] pa, input logic [31:0] pd,
                                 input logic lv, input logic [5:0] la, input logic [31:0] ld);
        pipe_we    = pwe;
        pipe_waddr = pa;
        pipe_wdata = pd;
        ll_valid   = lv;
        ll_waddr   = la;
        ll_wdata   = ld;
    endtask

    task automatic expectWrite(input logic [5:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Every register-file write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 32'(rf_we), 32'd0);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("wr_addr", 32'(rf_waddr), 32'(monEntry.addr));
                checkOutput("wr_data", rf_wdata, monEntry.data);
            end
        end else begin
            checkOutput("idle_waddr", 32'(rf_waddr), 32'd0);
            checkOutput("idle_wdata", rf_wdata, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [5:0]  llAddr [3];
        logic [31:0] llData [3];
        int          j;
        int          n;

        llAddr[0] = 6'd11; llData[0] = 32'hB1;
        llAddr[1] = 6'd12; llData[1] = 32'hB2;
        llAddr[2] = 6'd13; llData[2] = 32'hB3;

        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        reset = 1'b1;
        #2;
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst_stall", 32'(pipe_stall), 32'd0);
        checkOutput("rst_ready", 32'(ll_ready), 32'd1);
        checkOutput("rst_pending", 32'(ll_pending), 32'd0);
        checkOutput("rst_count", 32'(ll_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle pipeline: a buffered result appears one cycle after acceptance.
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 32'h1234);
        expectWrite(6'd5, 32'h1234);
        @(negedge clk);
        checkOutput("s1_no_bypass", 32'(rf_we), 32'd0);
        nextCycle;
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        checkOutput("s1_we", 32'(rf_we), 32'd1);
        checkOutput("s1_count_c1", 32'(ll_count), 32'd1);
        nextCycle;
        @(negedge clk);
        checkOutput("s1_count_c2", 32'(ll_count), 32'd0);

        // Busy pipeline: starvation forces a drain on cycle 5.
        for (int k = 0; k <= 6; k++) begin
            nextCycle;
            applyStimulus(1'b1, 6'd8, 32'h88, k == 0, 6'd9, 32'h99);
            if (k == 5) expectWrite(6'd9, 32'h99);
            else        expectWrite(6'd8, 32'h88);
            @(negedge clk);
            checkOutput($sformatf("s2_stall_%0d", k), 32'(pipe_stall), 32'(k == 5));
        end
        nextCycle;
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        checkOutput("s2_count_end", 32'(ll_count), 32'd0);

        // Full buffer backpressure with FIFO ordering under a busy pipeline.
        j = 0;
        for (int k = 0; k <= 15; k++) begin
            nextCycle;
            if (j < 3) applyStimulus(1'b1, 6'd10, 32'hA0, 1'b1, llAddr[j], llData[j]);
            else       applyStimulus(1'b1, 6'd10, 32'hA0, 1'b0, 6'd0, 32'd0);
            if (k == 5 || k == 10 || k == 15) begin
                n = k / 5 - 1;
                expectWrite(llAddr[n], llData[n]);
            end else begin
                expectWrite(6'd10, 32'hA0);
            end
            @(negedge clk);
            checkOutput($sformatf("s3_stall_%0d", k), 32'(pipe_stall),
                        32'(k == 5 || k == 10 || k == 15));
            if (k <= 6)
                checkOutput($sformatf("s3_ready_%0d", k), 32'(ll_ready), 32'(k < 2 || k == 6));
            if (k == 2)
                checkOutput("s3_count_full", 32'(ll_count), 32'd2);
            if (ll_valid && ll_ready) j++;
        end
        nextCycle;
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        checkOutput("s3_count_end", 32'(ll_count), 32'd0);
        checkOutput("s3_all_accepted", 32'(j), 32'd3);

        // A younger pipe write kills the buffered entry for the same register.
        nextCycle;
        applyStimulus(1'b1, 6'd20, 32'h2020, 1'b1, 6'd7, 32'hAAAA);
        expectWrite(6'd20, 32'h2020);
        @(negedge clk);
        nextCycle;
        applyStimulus(1'b1, 6'd7, 32'hBBBB, 1'b0, 6'd0, 32'd0);
        expectWrite(6'd7, 32'hBBBB);
        @(negedge clk);
        checkOutput("s4_pending_c1", 32'(ll_pending), 32'd1);
        nextCycle;
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        checkOutput("s4_drop_no_write", 32'(rf_we), 32'd0);
        checkOutput("s4_pending_c2", 32'(ll_pending), 32'd1);
        nextCycle;
        @(negedge clk);
        checkOutput("s4_count_end", 32'(ll_count), 32'd0);

        // Same-cycle collision: the entry is enqueued already dead.
        nextCycle;
        applyStimulus(1'b1, 6'd21, 32'hDDDD, 1'b1, 6'd21, 32'hCCCC);
        expectWrite(6'd21, 32'hDDDD);
        @(negedge clk);
        nextCycle;
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        checkOutput("s4b_no_write", 32'(rf_we), 32'd0);
        nextCycle;
        @(negedge clk);
        checkOutput("s4b_count_end", 32'(ll_count), 32'd0);

        // Register zero is never written from either source.
        nextCycle;
        applyStimulus(1'b1, 6'd0, 32'h55, 1'b1, 6'd0, 32'h66);
        @(negedge clk);
        checkOutput("s5_we_c0", 32'(rf_we), 32'd0);
        nextCycle;
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        checkOutput("s5_we_c1", 32'(rf_we), 32'd0);
        nextCycle;
        @(negedge clk);
        checkOutput("s5_count_end", 32'(ll_count), 32'd0);

        // Asynchronous reset with two entries queued discards them at once.
        nextCycle;
        applyStimulus(1'b1, 6'd30, 32'h3030, 1'b1, 6'd1, 32'h11);
        expectWrite(6'd30, 32'h3030);
        @(negedge clk);
        nextCycle;
        applyStimulus(1'b1, 6'd30, 32'h3030, 1'b1, 6'd2, 32'h22);
        expectWrite(6'd30, 32'h3030);
        @(negedge clk);
        checkOutput("s6_count_c1", 32'(ll_count), 32'd1);
        nextCycle;
        checkOutput("s6_count_full", 32'(ll_count), 32'd2);
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("s6_rst_we", 32'(rf_we), 32'd0);
        checkOutput("s6_rst_wdata", rf_wdata, 32'd0);
        checkOutput("s6_rst_count", 32'(ll_count), 32'd0);
        checkOutput("s6_rst_pending", 32'(ll_pending), 32'd0);
        checkOutput("s6_rst_ready", 32'(ll_ready), 32'd1);
        checkOutput("s6_rst_stall", 32'(pipe_stall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("s6_count_after", 32'(ll_count), 32'd0);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
